// File: rtl/cga_mac_apos_addr_gen.sv
// Multi-channel CGA MAC address generator: per-channel current-address registers
// updated on MCLK strobes, with an auto-increment burst engine and MCA/ECCR capture.
module cga_mac_apos_addr_gen #(
  parameter  int WIDTH      = 16,
  parameter  int CHANNELS   = 2,
  parameter  int MCA_WIDTH  = 10,
  parameter  int STEP_WIDTH = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  sysclk,
  input  logic                  sys_rst_n,
  input  logic                  MCLK,
  input  logic [CHW-1:0]        CHSEL,
  input  logic [2:0]            SRCSEL,
  input  logic [WIDTH-1:0]      PR_IN,
  input  logic [WIDTH-1:0]      ADD_IN,
  input  logic [WIDTH-1:0]      CD_IN,
  input  logic [STEP_WIDTH-1:0] STEP,
  input  logic                  BURST_START,
  input  logic [CNT_WIDTH-1:0]  BURST_LEN,
  input  logic                  BURST_ABORT,
  input  logic                  ECCRHIN,
  output logic [WIDTH-1:0]      ICA,
  output logic [WIDTH-1:0]      LCA,
  output logic [WIDTH-1:0]      NLCA,
  output logic [MCA_WIDTH-1:0]  MCA,
  output logic                  ECCR,
  output logic                  BURST_BUSY,
  output logic                  BURST_DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] SRC_PR  = 3'd1;
  localparam logic [2:0] SRC_ADD = 3'd2;
  localparam logic [2:0] SRC_CD  = 3'd3;
  localparam logic [2:0] SRC_INC = 3'd4;
  localparam logic [2:0] SRC_DEC = 3'd5;

  state_t               r_state;
  logic [CHW-1:0]       r_burstCh;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_lca [CHANNELS];
  logic [MCA_WIDTH-1:0] r_mca;
  logic                 r_eccr;
  logic                 r_busy;
  logic                 r_done;

  logic [CHW-1:0]       w_chSel;
  logic [CHW-1:0]       w_activeCh;
  logic [2:0]           w_mode;
  logic [WIDTH-1:0]     w_lca;
  logic [WIDTH-1:0]     w_step;
  logic [WIDTH-1:0]     w_ica;

  // Out-of-range channel selects fold onto channel 0.
  assign w_chSel    = (int'(CHSEL) >= CHANNELS) ? '0 : CHSEL;
  assign w_activeCh = (r_state == ST_IDLE) ? w_chSel : r_burstCh;
  assign w_mode     = (r_state == ST_RUN) ? SRC_INC : SRCSEL;
  assign w_lca      = r_lca[w_activeCh];
  assign w_step     = WIDTH'(STEP);

  always_comb begin
    w_ica = w_lca;
    case (w_mode)
      SRC_PR:  w_ica = PR_IN;
      SRC_ADD: w_ica = ADD_IN;
      SRC_CD:  w_ica = CD_IN;
      SRC_INC: w_ica = w_lca + w_step;
      SRC_DEC: w_ica = w_lca - w_step;
      default: w_ica = w_lca;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_lca[i] <= '0;
      r_mca  <= '0;
      r_eccr <= 1'b0;
    end else if (MCLK) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_activeCh == CHW'(i)) r_lca[i] <= w_ica;
      end
      r_mca  <= w_ica[MCA_WIDTH-1:0];
      r_eccr <= ECCRHIN;
    end
  end

  // Burst engine; an abort in RUN still lets the coincident strobe step the address.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_burstCh <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (BURST_START) begin
            r_burstCh <= w_chSel;
            r_cnt     <= BURST_LEN;
            if (BURST_LEN == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (BURST_ABORT) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (MCLK) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
            if (r_cnt == CNT_WIDTH'(1)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ICA        = w_ica;
  assign LCA        = w_lca;
  assign NLCA       = w_lca + w_step;
  assign MCA        = r_mca;
  assign ECCR       = r_eccr;
  assign BURST_BUSY = r_busy;
  assign BURST_DONE = r_done;

endmodule

// File: tb/tb_cga_mac_apos_addr_gen.sv
// Directed self-checking bench for cga_mac_apos_addr_gen with hand-computed expectations.
module tb_cga_mac_apos_addr_gen;

  logic        sysclk;
  logic        sys_rst_n;
  logic        MCLK;
  logic [0:0]  CHSEL;
  logic [2:0]  SRCSEL;
  logic [15:0] PR_IN, ADD_IN, CD_IN;
  logic [3:0]  STEP;
  logic        BURST_START;
  logic [7:0]  BURST_LEN;
  logic        BURST_ABORT;
  logic        ECCRHIN;
  logic [15:0] ICA, LCA, NLCA;
  logic [9:0]  MCA;
  logic        ECCR, BURST_BUSY, BURST_DONE;

  int nErrors = 0;
  int nChecks = 0;

  cga_mac_apos_addr_gen #(
    .WIDTH(16), .CHANNELS(2), .MCA_WIDTH(10), .STEP_WIDTH(4), .CNT_WIDTH(8)
  ) dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .MCLK(MCLK), .CHSEL(CHSEL), .SRCSEL(SRCSEL),
    .PR_IN(PR_IN), .ADD_IN(ADD_IN), .CD_IN(CD_IN), .STEP(STEP),
    .BURST_START(BURST_START), .BURST_LEN(BURST_LEN), .BURST_ABORT(BURST_ABORT),
    .ECCRHIN(ECCRHIN), .ICA(ICA), .LCA(LCA), .NLCA(NLCA), .MCA(MCA), .ECCR(ECCR),
    .BURST_BUSY(BURST_BUSY), .BURST_DONE(BURST_DONE)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mclk, input logic [0:0] chsel,
                               input logic [2:0] srcsel, input logic [3:0] step);
    MCLK   = mclk;
    CHSEL  = chsel;
    SRCSEL = srcsel;
    STEP   = step;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge sysclk);
    #2;
  endtask

  initial begin
    sys_rst_n = 1'b0; MCLK = 0; CHSEL = 0; SRCSEL = 0; STEP = 0;
    PR_IN = 0; ADD_IN = 0; CD_IN = 0;
    BURST_START = 0; BURST_LEN = 0; BURST_ABORT = 0; ECCRHIN = 0;
    #12;
    checkOutput("rst_lca", 32'(LCA), 32'h0);
    checkOutput("rst_mca", 32'(MCA), 32'h0);
    checkOutput("rst_eccr", 32'(ECCR), 32'h0);
    checkOutput("rst_busy", 32'(BURST_BUSY), 32'h0);
    checkOutput("rst_done", 32'(BURST_DONE), 32'h0);
    sys_rst_n = 1'b1;
    nextCycle();

    // Load channel 1 from PR
    PR_IN = 16'h1234;
    applyStimulus(1'b1, 1'b1, 3'd1, 4'd0);
    checkOutput("pr_ica", 32'(ICA), 32'h1234);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd0);
    checkOutput("pr_lca_ch1", 32'(LCA), 32'h1234);
    checkOutput("pr_mca", 32'(MCA), 32'h234);
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0);
    checkOutput("pr_lca_ch0", 32'(LCA), 32'h0);

    // Wrap-around INC / DEC on channel 0
    PR_IN = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 3'd1, 4'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 3'd4, 4'd1);
    checkOutput("inc_ica", 32'(ICA), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd4, 4'd1);
    checkOutput("inc_lca", 32'(LCA), 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd5, 4'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd5);
    checkOutput("dec_lca", 32'(LCA), 32'hFFFF);
    checkOutput("hold_nlca", 32'(NLCA), 32'h0004);
    checkOutput("hold_ica", 32'(ICA), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, 3'd7, 4'd5);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd5);
    checkOutput("hold_lca", 32'(LCA), 32'hFFFF);
    checkOutput("hold_mca", 32'(MCA), 32'h3FF);

    // ECCR only captured on strobes
    ECCRHIN = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0);
    nextCycle();
    checkOutput("eccr_nostrobe", 32'(ECCR), 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0);
    checkOutput("eccr_strobe", 32'(ECCR), 32'h1);
    ECCRHIN = 1'b0;

    // Burst of 3, STEP=2, on channel 1 starting at 0x0100
    PR_IN = 16'h0100;
    applyStimulus(1'b1, 1'b1, 3'd1, 4'd0);
    nextCycle();
    BURST_START = 1'b1; BURST_LEN = 8'd3;
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd2);
    checkOutput("bst_busy_start", 32'(BURST_BUSY), 32'h0);
    nextCycle();
    BURST_START = 1'b0; PR_IN = 16'hAAAA;
    applyStimulus(1'b0, 1'b0, 3'd1, 4'd2);
    checkOutput("bst_busy_run", 32'(BURST_BUSY), 32'h1);
    checkOutput("bst_lca_run", 32'(LCA), 32'h0100);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, 3'd1, 4'd2);
      checkOutput("bst_ica", 32'(ICA), 32'h0100 + 32'(2 * k));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 3'd1, 4'd2);
      checkOutput("bst_lca", 32'(LCA), 32'h0100 + 32'(2 * k));
      checkOutput("bst_busy", 32'(BURST_BUSY), (k < 3) ? 32'h1 : 32'h0);
      checkOutput("bst_done", 32'(BURST_DONE), (k == 3) ? 32'h1 : 32'h0);
      if (k < 3) nextCycle();
    end
    checkOutput("bst_mca", 32'(MCA), 32'h106);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd2);
    checkOutput("bst_done_once", 32'(BURST_DONE), 32'h0);
    checkOutput("bst_ch0_untouched", 32'(LCA), 32'hFFFF);

    // Zero-length burst
    BURST_START = 1'b1; BURST_LEN = 8'd0;
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd2);
    nextCycle();
    BURST_START = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd2);
    checkOutput("z_busy", 32'(BURST_BUSY), 32'h0);
    checkOutput("z_done", 32'(BURST_DONE), 32'h1);
    checkOutput("z_lca", 32'(LCA), 32'h0106);
    nextCycle();
    checkOutput("z_done_clr", 32'(BURST_DONE), 32'h0);

    // Burst of 5 aborted on the third strobe
    BURST_START = 1'b1; BURST_LEN = 8'd5;
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd1);
    nextCycle();
    BURST_START = 1'b0;
    checkOutput("ab_busy", 32'(BURST_BUSY), 32'h1);
    applyStimulus(1'b1, 1'b1, 3'd0, 4'd1);
    nextCycle();
    nextCycle();
    BURST_ABORT = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd0, 4'd1);
    nextCycle();
    BURST_ABORT = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd1);
    checkOutput("ab_busy_low", 32'(BURST_BUSY), 32'h0);
    checkOutput("ab_no_done", 32'(BURST_DONE), 32'h0);
    checkOutput("ab_lca", 32'(LCA), 32'h0109);
    nextCycle();
    checkOutput("ab_no_done_late", 32'(BURST_DONE), 32'h0);

    // Reset asserted mid-burst
    BURST_START = 1'b1; BURST_LEN = 8'd5; ECCRHIN = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd1);
    nextCycle();
    BURST_START = 1'b0;
    applyStimulus(1'b1, 1'b1, 3'd0, 4'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd1);
    checkOutput("mr_pre_lca", 32'(LCA), 32'h010A);
    checkOutput("mr_pre_eccr", 32'(ECCR), 32'h1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("mr_lca", 32'(LCA), 32'h0);
    checkOutput("mr_mca", 32'(MCA), 32'h0);
    checkOutput("mr_eccr", 32'(ECCR), 32'h0);
    checkOutput("mr_busy", 32'(BURST_BUSY), 32'h0);
    checkOutput("mr_done", 32'(BURST_DONE), 32'h0);
    sys_rst_n = 1'b1; ECCRHIN = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd1);
    checkOutput("mr_after_done", 32'(BURST_DONE), 32'h0);
    checkOutput("mr_after_ch0", 32'(LCA), 32'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
